// File: rtl/cfg_loader.sv
// rtl/cfg_loader.sv - BRAM-swept config loader with atomic commit; CFG_LOADER_STATUS_WB_EN adds STATUS write-back
module cfg_loader #(
  parameter int WIDTH  = 13,
  parameter int DEPTH  = 249,
  parameter int ADDR_W = 9
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  output logic [ADDR_W-1:0]        BRAM_ADDR,
  input  logic [15:0]              BRAM_DOUT,
  output logic                     BRAM_WE,
  output logic [15:0]              BRAM_DIN,
  input  logic                     THERMO,
  output logic                     FAN_ACT,
  output logic [15:0]              ECAT_SYNC_CYCLE_TICKS,
  output logic [63:0]              ECAT_SYNC_TIME,
  output logic                     SYNC_SET,
  output logic [15:0]              CYCLE_M,
  output logic [31:0]              FREQ_DIV_M,
  output logic [15:0]              CYCLE_S,
  output logic [WIDTH-1:0]         STEP_S,
  output logic [15:0]              CYCLE_STM,
  output logic [31:0]              FREQ_DIV_STM,
  output logic [31:0]              SOUND_SPEED,
  output logic [DEPTH*WIDTH-1:0]   CYCLE
);

  typedef enum logic [2:0] {SCALAR, CHECK, TABLE, COMMIT, WB} state_t;

  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SC_ISSUE  = ADDR_W'(16);
  localparam logic [ADDR_W-1:0] SC_LAST   = ADDR_W'(17);
  localparam logic [ADDR_W-1:0] TBL_BASE  = ADDR_W'(256);
  localparam logic [ADDR_W-1:0] TBL_ISSUE = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] TBL_LAST  = ADDR_W'(DEPTH + 1);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cnt, cnt_n;
  logic                issue;

  // Tag pipeline mirrors the 2-cycle BRAM read latency
  logic                tag1_v, tag1_tbl, tag2_v, tag2_tbl;
  logic [ADDR_W-1:0]   tag1_idx, tag2_idx;

  logic [1:0]          ctl_sh;
  logic                prev_req;
  logic [15:0]         ticks_sh, cm_sh, cs_sh, cstm_sh;
  logic [63:0]         time_sh;
  logic [31:0]         fdm_sh, fdstm_sh, ss_sh;
  logic [WIDTH-1:0]    step_sh;
  logic [WIDTH-1:0]    cyc_sh [DEPTH];
`ifdef CFG_LOADER_STATUS_WB_EN
  logic [7:0]          commit_cnt;
`endif

  logic req;
  assign req = ctl_sh[0] & ~prev_req;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= SCALAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    issue     = 1'b0;
    BRAM_ADDR = '0;
    BRAM_WE   = 1'b0;
    BRAM_DIN  = 16'h0000;
    case (state)
      SCALAR: begin
        if (cnt < SC_ISSUE) begin
          issue     = 1'b1;
          BRAM_ADDR = cnt;
        end
        if (cnt == SC_LAST) begin
          state_n = CHECK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      CHECK: begin
        cnt_n   = '0;
        state_n = req ? TABLE : SCALAR;
      end
      TABLE: begin
        if (cnt < TBL_ISSUE) begin
          issue     = 1'b1;
          BRAM_ADDR = TBL_BASE + cnt;
        end
        if (cnt == TBL_LAST) begin
          state_n = COMMIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      COMMIT: state_n = WB;
      WB: begin
        state_n = SCALAR;
`ifdef CFG_LOADER_STATUS_WB_EN
        BRAM_ADDR = ADDR_W'(16);
        BRAM_WE   = 1'b1;
        BRAM_DIN  = {8'h00, commit_cnt};
`endif
      end
      default: state_n = SCALAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tag1_v <= 1'b0; tag1_tbl <= 1'b0; tag1_idx <= '0;
      tag2_v <= 1'b0; tag2_tbl <= 1'b0; tag2_idx <= '0;
      ctl_sh <= '0; prev_req <= 1'b0;
      ticks_sh <= '0; time_sh <= '0; cm_sh <= '0; fdm_sh <= '0; cs_sh <= '0;
      step_sh <= '0; cstm_sh <= '0; fdstm_sh <= '0; ss_sh <= '0;
      for (int i = 0; i < DEPTH; i++) cyc_sh[i] <= '0;
      FAN_ACT <= 1'b0; SYNC_SET <= 1'b0;
      ECAT_SYNC_CYCLE_TICKS <= '0; ECAT_SYNC_TIME <= '0;
      CYCLE_M <= '0; FREQ_DIV_M <= '0; CYCLE_S <= '0; STEP_S <= '0;
      CYCLE_STM <= '0; FREQ_DIV_STM <= '0; SOUND_SPEED <= '0;
      CYCLE <= '0;
`ifdef CFG_LOADER_STATUS_WB_EN
      commit_cnt <= 8'h00;
`endif
    end else begin
      tag1_v   <= issue;
      tag1_tbl <= (state == TABLE);
      tag1_idx <= cnt;
      tag2_v   <= tag1_v;
      tag2_tbl <= tag1_tbl;
      tag2_idx <= tag1_idx;

      if (tag2_v && !tag2_tbl) begin
        case (tag2_idx[3:0])
          4'h0: ctl_sh          <= BRAM_DOUT[1:0];
          4'h1: ticks_sh        <= BRAM_DOUT;
          4'h2: time_sh[15:0]   <= BRAM_DOUT;
          4'h3: time_sh[31:16]  <= BRAM_DOUT;
          4'h4: time_sh[47:32]  <= BRAM_DOUT;
          4'h5: time_sh[63:48]  <= BRAM_DOUT;
          4'h6: cm_sh           <= BRAM_DOUT;
          4'h7: fdm_sh[15:0]    <= BRAM_DOUT;
          4'h8: fdm_sh[31:16]   <= BRAM_DOUT;
          4'h9: cs_sh           <= BRAM_DOUT;
          4'hA: step_sh         <= BRAM_DOUT[WIDTH-1:0];
          4'hB: cstm_sh         <= BRAM_DOUT;
          4'hC: fdstm_sh[15:0]  <= BRAM_DOUT;
          4'hD: fdstm_sh[31:16] <= BRAM_DOUT;
          4'hE: ss_sh[15:0]     <= BRAM_DOUT;
          default: ss_sh[31:16] <= BRAM_DOUT;
        endcase
      end
      if (tag2_v && tag2_tbl) begin
        for (int i = 0; i < DEPTH; i++)
          if (tag2_idx == ADDR_W'(i)) cyc_sh[i] <= BRAM_DOUT[WIDTH-1:0];
      end

      FAN_ACT  <= THERMO | ctl_sh[1];
      SYNC_SET <= (state == COMMIT);

      // The last scalar word lands on the edge into CHECK, so publish on the way out
      if (state == CHECK) begin
        prev_req     <= ctl_sh[0];
        CYCLE_M      <= cm_sh;
        FREQ_DIV_M   <= fdm_sh;
        CYCLE_S      <= cs_sh;
        STEP_S       <= step_sh;
        CYCLE_STM    <= cstm_sh;
        FREQ_DIV_STM <= fdstm_sh;
        SOUND_SPEED  <= ss_sh;
      end

      if (state == COMMIT) begin
        ECAT_SYNC_CYCLE_TICKS <= ticks_sh;
        ECAT_SYNC_TIME        <= time_sh;
        for (int i = 0; i < DEPTH; i++) CYCLE[i*WIDTH +: WIDTH] <= cyc_sh[i];
`ifdef CFG_LOADER_STATUS_WB_EN
        commit_cnt <= commit_cnt + 8'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// tb/tb_cfg_loader.sv - directed vector bench for cfg_loader with a 2-cycle BRAM model
module tb_cfg_loader;
  localparam int WIDTH  = 13;
  localparam int DEPTH  = 249;
  localparam int ADDR_W = 9;
`ifdef CFG_LOADER_STATUS_WB_EN
  localparam logic [15:0] EXP_STATUS = 16'h0002;
  localparam int          EXP_WE     = 4;
`else
  localparam logic [15:0] EXP_STATUS = 16'h0000;
  localparam int          EXP_WE     = 0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [ADDR_W-1:0]      bram_addr;
  logic [15:0]            bram_dout;
  logic                   bram_we;
  logic [15:0]            bram_din;
  logic                   thermo = 1'b0;
  logic                   fan_act;
  logic [15:0]            ticks;
  logic [63:0]            stime;
  logic                   sync_set;
  logic [15:0]            cycle_m, cycle_s, cycle_stm;
  logic [31:0]            freq_div_m, freq_div_stm, sound_speed;
  logic [WIDTH-1:0]       step_s;
  logic [DEPTH*WIDTH-1:0] cycle;

  cfg_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST_N(rst_n),
    .BRAM_ADDR(bram_addr), .BRAM_DOUT(bram_dout), .BRAM_WE(bram_we), .BRAM_DIN(bram_din),
    .THERMO(thermo), .FAN_ACT(fan_act),
    .ECAT_SYNC_CYCLE_TICKS(ticks), .ECAT_SYNC_TIME(stime), .SYNC_SET(sync_set),
    .CYCLE_M(cycle_m), .FREQ_DIV_M(freq_div_m), .CYCLE_S(cycle_s), .STEP_S(step_s),
    .CYCLE_STM(cycle_stm), .FREQ_DIV_STM(freq_div_stm), .SOUND_SPEED(sound_speed),
    .CYCLE(cycle)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [512] = '{default: 16'h0000};
  logic [15:0] rd1 = 16'h0, rd2 = 16'h0;
  logic        host_we = 1'b0;
  logic [8:0]  host_addr = 9'h0;
  logic [15:0] host_data = 16'h0;

  always @(posedge clk) begin
    rd1 <= mem[bram_addr];
    rd2 <= rd1;
    if (bram_we) mem[bram_addr] <= bram_din;
    if (host_we) mem[host_addr] <= host_data;
  end
  assign bram_dout = rd2;

  int sync_cnt = 0;
  int we_cnt = 0;
  always @(negedge clk) begin
    if (sync_set) sync_cnt <= sync_cnt + 1;
    if (bram_we) we_cnt <= we_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [8:0] a, input logic [15:0] d);
    host_addr = a; host_data = d; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sync(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (sync_set) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_addr(input logic [ADDR_W-1:0] a, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bram_addr == a) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 64'(bram_addr), 64'h0);
    chk({tag, "_we_din"}, {47'h0, bram_we, bram_din}, 64'h0);
    chk({tag, "_fan_sync"}, {62'h0, fan_act, sync_set}, 64'h0);
    chk({tag, "_ticks"}, 64'(ticks), 64'h0);
    chk({tag, "_time"}, stime, 64'h0);
    chk({tag, "_scalars"}, 64'(|{cycle_m, freq_div_m, cycle_s, step_s, cycle_stm, freq_div_stm, sound_speed}), 64'h0);
    chk({tag, "_cycle"}, 64'(|cycle), 64'h0);
  endtask

  typedef struct {
    logic [15:0] cm;
    logic [31:0] fdm;
    logic [15:0] cs;
    logic [15:0] step_w;
    logic [15:0] cstm;
    logic [31:0] fdstm;
    logic [31:0] ss;
    logic        thermo;
    logic [15:0] ctl;
    logic [12:0] exp_step;
    logic        exp_fan;
  } vec_t;

  vec_t vecs [3];
  logic [WIDTH-1:0] exp_cyc [DEPTH];

  initial begin
    int lat, sc0, nbad;
    bit seen;
    logic [WIDTH-1:0] new0;

    vecs[0] = '{16'h1234, 32'hDEAD_BEEF, 16'h0001, 16'hFFFF, 16'h8000, 32'h0000_0001, 32'h0001_5F90, 1'b1, 16'h0000, 13'h1FFF, 1'b1};
    vecs[1] = '{16'h0000, 32'h0000_0000, 16'h0000, 16'h2000, 16'h5A5A, 32'h1234_5678, 32'h0000_0000, 1'b0, 16'h0000, 13'h0000, 1'b0};
    vecs[2] = '{16'hFFFF, 32'h0001_0000, 16'hABCD, 16'hE005, 16'h0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 16'h0002, 13'h0005, 1'b1};

    rst_n = 1'b0;
    wait_cyc(4);
    check_zero("reset");
    rst_n = 1'b1;

    for (int v = 0; v < 3; v++) begin
      host_write(9'h006, vecs[v].cm);
      host_write(9'h007, vecs[v].fdm[15:0]);
      host_write(9'h008, vecs[v].fdm[31:16]);
      host_write(9'h009, vecs[v].cs);
      host_write(9'h00A, vecs[v].step_w);
      host_write(9'h00B, vecs[v].cstm);
      host_write(9'h00C, vecs[v].fdstm[15:0]);
      host_write(9'h00D, vecs[v].fdstm[31:16]);
      host_write(9'h00E, vecs[v].ss[15:0]);
      host_write(9'h00F, vecs[v].ss[31:16]);
      thermo = vecs[v].thermo;
      host_write(9'h000, vecs[v].ctl);
      sc0 = sync_cnt;
      wait_cyc(100);
      chk($sformatf("v%0d_cycle_m", v), 64'(cycle_m), 64'(vecs[v].cm));
      chk($sformatf("v%0d_freq_div_m", v), 64'(freq_div_m), 64'(vecs[v].fdm));
      chk($sformatf("v%0d_cycle_s", v), 64'(cycle_s), 64'(vecs[v].cs));
      chk($sformatf("v%0d_step_s", v), 64'(step_s), 64'(vecs[v].exp_step));
      chk($sformatf("v%0d_cycle_stm", v), 64'(cycle_stm), 64'(vecs[v].cstm));
      chk($sformatf("v%0d_freq_div_stm", v), 64'(freq_div_stm), 64'(vecs[v].fdstm));
      chk($sformatf("v%0d_sound_speed", v), 64'(sound_speed), 64'(vecs[v].ss));
      chk($sformatf("v%0d_fan", v), 64'(fan_act), 64'(vecs[v].exp_fan));
      chk($sformatf("v%0d_no_sync", v), 64'(sync_cnt), 64'(sc0));
    end
    thermo = 1'b0;

    // Table load and first commit
    for (int i = 0; i < DEPTH; i++) begin
      exp_cyc[i] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      host_write(9'(256 + i), 16'(exp_cyc[i]));
    end
    host_write(9'h001, 16'h1234);
    host_write(9'h002, 16'hCDEF);
    host_write(9'h003, 16'h89AB);
    host_write(9'h004, 16'h4567);
    host_write(9'h005, 16'h0123);
    wait_cyc(40);
    chk("cycle_before_commit", 64'(|cycle), 64'h0);
    host_write(9'h000, 16'h0001);
    wait_sync(400, lat);
    chk("sync1_seen", 64'(lat > 0), 64'h1);
    chk("sync1_latency_le_291", 64'(lat <= 291), 64'h1);
    nbad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (cycle[i*WIDTH +: WIDTH] !== exp_cyc[i]) nbad++;
    chk("cycle_slices_bad", 64'(nbad), 64'h0);
    chk("sync_ticks", 64'(ticks), 64'h1234);
    chk("sync_time", stime, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    chk("sync1_pulse_width", 64'(sync_set), 64'h0);

    // Held request commits once; re-arm commits again
    wait_cyc(2000);
    chk("held_one_commit", 64'(sync_cnt), 64'h1);
    host_write(9'h000, 16'h0000);
    wait_cyc(60);
    host_write(9'h000, 16'h0001);
    wait_sync(400, lat);
    chk("sync2_seen", 64'(lat > 0), 64'h1);
    wait_cyc(5);
    chk("second_commit_count", 64'(sync_cnt), 64'h2);
    chk("status_word", 64'(mem[16]), 64'(EXP_STATUS));

    // Rewrite channel 0 after it was read in TABLE
    host_write(9'h000, 16'h0000);
    wait_cyc(60);
    new0 = ~exp_cyc[0];
    host_write(9'h000, 16'h0001);
    wait_addr(ADDR_W'(256 + 50), 400, seen);
    chk("table_seen", 64'(seen), 64'h1);
    host_write(9'h100, 16'(new0));
    wait_sync(400, lat);
    chk("sync3_seen", 64'(lat > 0), 64'h1);
    chk("ch0_after_rewrite", 64'(cycle[WIDTH-1:0]), 64'(exp_cyc[0]));
    wait_cyc(500);
    chk("ch0_still_old", 64'(cycle[WIDTH-1:0]), 64'(exp_cyc[0]));
    host_write(9'h000, 16'h0000);
    wait_cyc(60);
    host_write(9'h000, 16'h0001);
    wait_sync(400, lat);
    chk("ch0_new_commit", 64'(cycle[WIDTH-1:0]), 64'(new0));

    // Reset in the middle of a table sweep
    host_write(9'h000, 16'h0000);
    wait_cyc(60);
    host_write(9'h000, 16'h0001);
    wait_addr(ADDR_W'(256 + 100), 400, seen);
    chk("table2_seen", 64'(seen), 64'h1);
    host_write(9'h000, 16'h0000);
    sc0 = sync_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    wait_cyc(20);
    chk("reload_cycle_m", 64'(cycle_m), 64'hFFFF);
    chk("reload_sound_speed", 64'(sound_speed), 64'h8000_0000);
    wait_cyc(300);
    chk("midrst_no_sync", 64'(sync_cnt), 64'(sc0));
    chk("midrst_cycle_zero", 64'(|cycle), 64'h0);
    chk("midrst_time_zero", stime, 64'h0);
    chk("we_total", 64'(we_cnt), 64'(EXP_WE));

    // Fan control
    thermo = 1'b1;
    @(negedge clk);
    chk("fan_thermo", 64'(fan_act), 64'h1);
    thermo = 1'b0;
    wait_cyc(2);
    chk("fan_off", 64'(fan_act), 64'h0);
    host_write(9'h000, 16'h0002);
    wait_cyc(40);
    chk("fan_force", 64'(fan_act), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
